// File: rtl/r52_control.sv
// Fetch/execute sequencer for the R52 LMC datapath: PC, IR, field decode and
// per-instruction strobes for RAM1, RAM2, the Acc operand mux and Acc register.
module r52_control #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  timer555,
  input  logic                  reset_count,
  input  logic                  run,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] ram1_data,
  input  logic                  Z_flag,
  input  logic                  PZ_flag,
  input  logic                  in_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] ram1_addr,
  output logic [ADDR_WIDTH-1:0] ram2_addr,
  output logic                  ram2_we,
  output logic [1:0]            mux_sel,
  output logic                  acc_we,
  output logic                  in_ack,
  output logic                  out_valid,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_OUT_WAIT = 3'd2,
    S_IN_WAIT  = 3'd3,
    S_EXEC     = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  state_t                st, st_nxt;
  logic [DATA_WIDTH-1:0] ir, ir_nxt;
  logic [ADDR_WIDTH-1:0] pc_r, pc_nxt;
  logic                  take_branch;

  function automatic logic needs_input(input logic [DATA_WIDTH-1:0] w);
    return w[10] & (w[8:7] == 2'b00);
  endfunction

  assign take_branch = ir[6] | (ir[5] & Z_flag) | (ir[4] & PZ_flag);

  always_comb begin
    st_nxt = st;
    ir_nxt = ir;
    pc_nxt = pc_r;
    case (st)
      S_IDLE:
        if (run || step) st_nxt = S_FETCH;
      S_FETCH: begin
        ir_nxt = ram1_data;
        if (ram1_data == '0)            st_nxt = S_HALT;
        else if (ram1_data[9])          st_nxt = S_OUT_WAIT;
        else if (needs_input(ram1_data)) st_nxt = S_IN_WAIT;
        else                            st_nxt = S_EXEC;
      end
      S_OUT_WAIT:
        if (out_ready) st_nxt = needs_input(ir) ? S_IN_WAIT : S_EXEC;
      S_IN_WAIT:
        if (in_valid) st_nxt = S_EXEC;
      S_EXEC: begin
        pc_nxt = take_branch ? ir[ADDR_WIDTH-1:0] : pc_r + ADDR_WIDTH'(1);
        st_nxt = run ? S_FETCH : S_IDLE;
      end
      S_HALT:
        st_nxt = S_HALT;
      default:
        st_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so each strobe is a clean
  // flop output that lines up exactly with the cycle its state is occupied.
  always_ff @(posedge timer555 or negedge reset_count) begin
    if (!reset_count) begin
      st        <= S_IDLE;
      ir        <= '0;
      pc_r      <= '0;
      ram2_we   <= 1'b0;
      acc_we    <= 1'b0;
      in_ack    <= 1'b0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      mux_sel   <= '0;
      ram2_addr <= '0;
    end else begin
      st        <= st_nxt;
      ir        <= ir_nxt;
      pc_r      <= pc_nxt;
      ram2_we   <= (st_nxt == S_EXEC) & ir_nxt[11];
      acc_we    <= (st_nxt == S_EXEC) & ir_nxt[10];
      in_ack    <= (st_nxt == S_EXEC) & needs_input(ir_nxt);
      out_valid <= (st_nxt == S_OUT_WAIT);
      halted    <= (st_nxt == S_HALT);
      if (st_nxt == S_EXEC || st_nxt == S_IN_WAIT) begin
        mux_sel   <= ir_nxt[8:7];
        ram2_addr <= ir_nxt[ADDR_WIDTH-1:0];
      end else begin
        mux_sel   <= '0;
        ram2_addr <= '0;
      end
    end
  end

  assign ram1_addr = pc_r;
  assign pc        = pc_r;
  assign state     = st;

endmodule

// File: tb/tb_r52_control.sv
// Directed bench for r52_control: behavioural RAM1 array, hand-computed expectations.
module tb_r52_control;

  logic        clk = 1'b0;
  logic        reset_count = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [11:0] ram1_data;
  logic        Z_flag = 1'b0;
  logic        PZ_flag = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  ram1_addr, ram2_addr, pc;
  logic        ram2_we, acc_we, in_ack, out_valid, halted;
  logic [1:0]  mux_sel;
  logic [2:0]  state;

  logic [11:0] mem [16];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;
  assign ram1_data = mem[ram1_addr];

  r52_control #(.ADDR_WIDTH(4), .DATA_WIDTH(12)) dut (
    .timer555(clk), .reset_count(reset_count), .run(run), .step(step),
    .ram1_data(ram1_data), .Z_flag(Z_flag), .PZ_flag(PZ_flag),
    .in_valid(in_valid), .out_ready(out_ready), .ram1_addr(ram1_addr),
    .ram2_addr(ram2_addr), .ram2_we(ram2_we), .mux_sel(mux_sel),
    .acc_we(acc_we), .in_ack(in_ack), .out_valid(out_valid),
    .halted(halted), .pc(pc), .state(state)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_count = 1'b0;
    @(negedge clk);
    reset_count = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
  endtask

  // Input, store, halt program: per-cycle state and strobe expectations.
  localparam logic [2:0] EXP_ST [7] = '{3'd1, 3'd3, 3'd4, 3'd1, 3'd4, 3'd1, 3'd5};
  localparam logic       EXP_AW [7] = '{0, 0, 1, 0, 0, 0, 0};
  localparam logic       EXP_IA [7] = '{0, 0, 1, 0, 0, 0, 0};
  localparam logic       EXP_RW [7] = '{0, 0, 0, 0, 1, 0, 0};
  localparam logic       EXP_HL [7] = '{0, 0, 0, 0, 0, 0, 1};

  initial begin
    clear_mem();

    // Test 1: 0x400 (input), 0x800 (STA 0), 0x000 (HLT)
    mem[0] = 12'h400; mem[1] = 12'h800; mem[2] = 12'h000;
    in_valid = 1'b1;
    run = 1'b1;
    apply_reset();
    check("rst_state", state, 0);
    check("rst_pc", pc, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_halted", halted, 0);
    for (int c = 0; c < 7; c++) begin
      tick();
      check($sformatf("t1_state_c%0d", c + 1), state, EXP_ST[c]);
      check($sformatf("t1_acc_we_c%0d", c + 1), acc_we, EXP_AW[c]);
      check($sformatf("t1_in_ack_c%0d", c + 1), in_ack, EXP_IA[c]);
      check($sformatf("t1_ram2_we_c%0d", c + 1), ram2_we, EXP_RW[c]);
      check($sformatf("t1_halted_c%0d", c + 1), halted, EXP_HL[c]);
      if (c == 4) check("t1_ram2_addr", ram2_addr, 0);
    end
    tick();
    check("t1_halt_sticky", state, 5);
    check("t1_halt_no_we", acc_we, 0);
    in_valid = 1'b0;

    // Test 2: BRP 8 with PZ_flag high, then low
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[0] = 12'h018;
      PZ_flag = (k == 0);
      apply_reset();
      tick();
      tick();
      check($sformatf("t2_exec_%0d", k), state, 4);
      check($sformatf("t2_pc_hold_%0d", k), ram1_addr, 0);
      tick();
      check($sformatf("t2_ram1_addr_%0d", k), ram1_addr, (k == 0) ? 8 : 1);
    end
    PZ_flag = 1'b0;

    // Test 3: OUT with out_ready held low for three sampled edges
    clear_mem();
    mem[0] = 12'h200;
    out_ready = 1'b0;
    apply_reset();
    tick();
    check("t3_fetch", state, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("t3_out_valid_%0d", c), out_valid, 1);
      check($sformatf("t3_wait_state_%0d", c), state, 2);
    end
    out_ready = 1'b1;
    tick();
    check("t3_exec", state, 4);
    check("t3_out_valid_drop", out_valid, 0);
    check("t3_pc_in_exec", pc, 0);
    run = 1'b0;
    tick();
    check("t3_pc_after", pc, 1);
    check("t3_idle", state, 0);
    out_ready = 1'b0;

    // Test 4: single-step ADD (0x480), one instruction per pulse
    clear_mem();
    mem[0] = 12'h480; mem[1] = 12'h480; mem[2] = 12'h480;
    run = 1'b0;
    apply_reset();
    tick(); tick();
    check("t4_idle_wait", state, 0);
    for (int s = 0; s < 2; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      check($sformatf("t4_fetch_%0d", s), state, 1);
      tick();
      check($sformatf("t4_exec_%0d", s), state, 4);
      check($sformatf("t4_acc_we_%0d", s), acc_we, 1);
      check($sformatf("t4_in_ack_%0d", s), in_ack, 0);
      check($sformatf("t4_mux_%0d", s), mux_sel, 1);
      tick();
      check($sformatf("t4_idle_%0d", s), state, 0);
      check($sformatf("t4_pc_%0d", s), pc, s + 1);
      check($sformatf("t4_mux_idle_%0d", s), mux_sel, 0);
    end

    // Test 5: BRA 15, word 15 = 0x700 (OUT + SUB) wraps PC to 0
    clear_mem();
    mem[0] = 12'h04F; mem[15] = 12'h700;
    out_ready = 1'b1;
    run = 1'b1;
    apply_reset();
    tick(); tick(); tick();
    check("t5_pc15", ram1_addr, 15);
    tick();
    check("t5_out_wait", state, 2);
    tick();
    check("t5_exec", state, 4);
    check("t5_acc_we", acc_we, 1);
    check("t5_mux_sub", mux_sel, 2);
    run = 1'b0;
    tick();
    check("t5_wrap", ram1_addr, 0);
    out_ready = 1'b0;

    // Test 6: async reset while waiting on output
    clear_mem();
    mem[0] = 12'h200;
    run = 1'b1;
    apply_reset();
    tick(); tick();
    check("t6_out_valid_pre", out_valid, 1);
    #2 reset_count = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_state", state, 0);
    check("t6_pc", pc, 0);
    check("t6_ram2_we", ram2_we, 0);
    check("t6_acc_we", acc_we, 0);
    run = 1'b0;
    @(negedge clk);
    reset_count = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/r52_control.md
# r52_control

Multi-cycle fetch/execute sequencer for the R52 LMC datapath: 4-bit program counter, 12-bit instruction register, one-hot field decode, and per-cycle strobes for RAM1 (program), RAM2 (data), the Acc operand mux and the Acc register. It replaces manual RAM1_button stepping, so a stored RAM1 program runs on timer555 with input/output handshakes, run/single-step control and halt.

## Interface
- ADDR_WIDTH, 4, PC / RAM address width
- DATA_WIDTH, 12, instruction word width
- timer555  in  1  system clock, rising edge
- reset_count  in  1  asynchronous, active-low reset (0 = reset)
- run  in  1  level; 1 = execute continuously
- step  in  1  one-cycle pulse; executes one instruction while run=0
- ram1_data  in  DATA_WIDTH  RAM1 read data (asynchronous read)
- Z_flag, PZ_flag  in  1  Acc==0 / Acc>=0 from datapath
- in_valid  in  1  input word on datapath input port is valid
- out_ready  in  1  output consumer accepts Acc
- ram1_addr  out  ADDR_WIDTH  = PC
- ram2_addr  out  ADDR_WIDTH  = IR[3:0]
- ram2_we  out  1  RAM2 write (stores Acc)
- mux_sel  out  2  Acc operand mux select
- acc_we  out  1  Acc load enable
- in_ack  out  1  input word consumed
- out_valid  out  1  Acc presented on output
- halted  out  1  HALT state
- pc  out  ADDR_WIDTH  program counter (debug)
- state  out  3  FSM state code (debug)

## Operation
- Decode of IR: [3:0] address; bit4 BRP; bit5 BRZ; bit6 BRA; {bit8,bit7} mux_sel (00 input port, 01 Acc+RAM2, 10 Acc−RAM2, 11 RAM2 direct); bit9 OUT; bit10 ACC_WE; bit11 STA. IR==0 is HLT.
- "Needs input" = ACC_WE & mux_sel==00.
- States: IDLE=0, FETCH=1, OUT_WAIT=2, IN_WAIT=3, EXEC=4, HALT=5.
- IDLE: run or step -> FETCH; else stay.
- FETCH: IR <= ram1_data. Next: HLT -> HALT; OUT -> OUT_WAIT; else needs input -> IN_WAIT; else EXEC.
- OUT_WAIT: out_valid=1; leave on out_valid&out_ready to IN_WAIT if needs input, else EXEC.
- IN_WAIT: wait for in_valid=1, then EXEC.
- EXEC (exactly one cycle): ram2_we=STA, acc_we=ACC_WE, mux_sel driven, in_ack=needs input. PC update: BRA, or BRZ&Z_flag, or BRP&PZ_flag -> PC <= IR[3:0]; else PC <= PC+1 mod 16 (15 -> 0). Next: run ? FETCH : IDLE.
- Multiple branch bits: taken if any enabled condition holds; target always IR[3:0].
- STA with ACC_WE: RAM2 receives pre-instruction Acc (both strobes same edge).
- Flags sampled in EXEC reflect Acc before this instruction's write.
- HALT: halted=1, all strobes 0; exit only by reset.
- run dropped mid-instruction: instruction completes, then IDLE. step ignored outside IDLE.
- mux_sel, ram2_addr are 0 outside EXEC/IN_WAIT (mux_sel held during IN_WAIT).

## Timing
- Reset (async, any state): state=IDLE, PC=0, IR=0; ram2_we, acc_we, in_ack, out_valid, halted=0; mux_sel=00; ram1_addr=0.
- Plain instruction: 2 cycles (FETCH, EXEC). OUT adds >=1 cycle; input adds >=1 cycle.
- All strobes are registered-state decodes, glitch-free, asserted for exactly the EXEC cycle.
- out_valid, once high, stays high until out_ready sampled high; Acc must not change meanwhile.
- in_ack is a single-cycle pulse coincident with acc_we.
- ram1_addr changes only on the edge leaving EXEC.

## Test plan
- Reset, run=1, RAM1: 0=0x400, 1=0x800, 2=0x000, in_valid=1 -> FETCH,IN_WAIT,EXEC(acc_we, in_ack),FETCH,EXEC(ram2_we, ram2_addr=0),FETCH,HALT; halted=1 at cycle 7.
- Word 0x018 (BRP 8): PZ_flag=1 -> next ram1_addr=8; PZ_flag=0 -> ram1_addr=1.
- Word 0x200, out_ready low 3 cycles then high -> out_valid high 4 cycles, EXEC once, PC 0->1.
- run=0, step pulses -> exactly one instruction per pulse, returns to IDLE, PC +1 each.
- BRA 15 (0x04F), word 15 = 0x700 -> after its EXEC, ram1_addr=0 (wrap).
- reset_count low during OUT_WAIT -> immediately out_valid=0, state=0, PC=0, no ram2_we/acc_we pulse.
